// File: rtl/mux_scan_capture_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_capture_pkg
//   Shared constants and types for the mux scan/capture sequencer.
//   - IDLE/SCAN/DONE : state encodings
//   - NUM_CH         : channels scanned per frame (one captured bit each)
//   - SEL_W          : width of the mux select code
// -----------------------------------------------------------------------------
package mux_scan_capture_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_SCAN = SCAN,
        S_DONE = DONE
    } state_e;

endpackage

// File: rtl/mux_scan_capture_if.sv
// -----------------------------------------------------------------------------
// mux_scan_capture_if
//   Bundles the sequencer's control, mux-side and downstream handshake signals.
//   master : the sequencer (drives sel, out_data, out_valid, busy)
//   slave  : the environment (drives start, y_in, out_ready)
// -----------------------------------------------------------------------------
interface mux_scan_capture_if;
    import mux_scan_capture_pkg::*;

    logic              start;
    logic [SEL_W-1:0]  sel;
    logic              y_in;
    logic [NUM_CH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        input  start, y_in, out_ready,
        output sel, out_data, out_valid, busy
    );

    modport slave (
        output start, y_in, out_ready,
        input  sel, out_data, out_valid, busy
    );

endinterface

// File: rtl/dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
//   Free-wrapping dwell timer: counts 0..DWELL-1 while enabled and flags the
//   last count so the owner can act once per dwell period.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : advance the count
//   tc       : count is at DWELL-1
// -----------------------------------------------------------------------------
module dwell_counter #(
    parameter int CNT_W = 4,
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            // wrap on terminal count so consecutive dwell periods need no clear
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_4_1_dec_buf.sv
// -----------------------------------------------------------------------------
// mux_4_1_dec_buf
//   4:1 multiplexer built as a 2->4 one-hot decoder gating per-input buffers
//   onto a shared line. The shared line is modelled as a wired-OR of the
//   enabled buffer, so exactly one input drives y for any select code.
//   sel : 2-bit select
//   in  : four parallel inputs
//   y   : selected input (combinational)
// -----------------------------------------------------------------------------
module mux_4_1_dec_buf (
    input  logic [1:0] sel,
    input  logic [3:0] in,
    output logic       y
);

    logic [3:0] dec;

    assign dec = 4'b0001 << sel;
    assign y   = |(dec & in);

endmodule

// File: rtl/mux_scan_capture.sv
// -----------------------------------------------------------------------------
// mux_scan_capture
//   Drives the select of a 4:1 mux through codes 0..3, holding each for DWELL
//   cycles, samples the mux output at the end of each dwell, and presents the
//   packed 4-bit word downstream on a valid/ready handshake.
//   clk, rst      : clock, async active-high reset
//   bus.start     : request a frame (level; looked at in IDLE and on transfer)
//   bus.sel       : registered mux select
//   bus.y_in      : mux output
//   bus.out_data  : captured word, bit k sampled while sel == k
//   bus.out_valid : word available
//   bus.out_ready : downstream accepts
//   bus.busy      : state is not IDLE
// -----------------------------------------------------------------------------
module mux_scan_capture
    import mux_scan_capture_pkg::*;
#(
    parameter int DWELL = 1,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux_scan_capture_if.master  bus
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_e            state;
    logic [SEL_W-1:0]  ch;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              scanning;
    logic              tc;

    assign scanning = (state == S_SCAN);

    // Held clear outside SCAN, so every frame starts its first dwell at zero.
    dwell_counter #(
        .CNT_W (CNT_W),
        .DWELL (DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (!scanning),
        .en  (scanning),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ch      <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    sel_q <= '0;
                    if (bus.start) begin
                        state  <= S_SCAN;
                        ch     <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (tc) begin
                        data_q[ch] <= bus.y_in;
                        if (ch == LAST_CH) begin
                            state   <= S_DONE;
                            ch      <= '0;
                            sel_q   <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            ch    <= ch + 1'b1;
                            sel_q <= ch + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // start only matters on the transfer edge; data is frozen
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        ch      <= '0;
                        if (bus.start) begin
                            state <= S_SCAN;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ch      <= '0;
                    sel_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_capture
//   Two sequencer+mux pairs (DWELL = 1 and DWELL = 3) on one clock and reset.
//   A frame-level reference model watches start/ready/in at the falling edge,
//   predicts sel and busy from the frame start time, samples the driven mux
//   inputs at the predicted sample edges and pushes each finished word into a
//   per-unit queue; a separate monitor compares out_valid/out_data against it.
// -----------------------------------------------------------------------------
module tb_mux_scan_capture;

    logic            clk;
    logic            rst;
    logic [1:0]      start_a;
    logic [1:0]      ready_a;
    logic [1:0][3:0] in_a;
    logic [1:0][1:0] sel_a;
    logic [1:0][3:0] od_a;
    logic [1:0]      ov_a;
    logic [1:0]      busy_a;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : u
        localparam int DW = (gi == 0) ? 1 : 3;
        mux_scan_capture_if bus ();
        logic y;

        assign bus.start     = start_a[gi];
        assign bus.out_ready = ready_a[gi];
        assign bus.y_in      = y;
        assign sel_a[gi]     = bus.sel;
        assign od_a[gi]      = bus.out_data;
        assign ov_a[gi]      = bus.out_valid;
        assign busy_a[gi]    = bus.busy;

        mux_4_1_dec_buf mux (
            .sel (bus.sel),
            .in  (in_a[gi]),
            .y   (y)
        );

        mux_scan_capture #(
            .DWELL (DW),
            .CNT_W (4)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard queues ----------------
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    function automatic int dw(int un);
        return (un == 0) ? 1 : 3;
    endfunction
    function automatic int qsize(int un);
        return (un == 0) ? q0.size() : q1.size();
    endfunction
    function automatic logic [3:0] qfront(int un);
        return (un == 0) ? q0[0] : q1[0];
    endfunction
    function automatic void qpush(int un, logic [3:0] w);
        if (un == 0) q0.push_back(w); else q1.push_back(w);
    endfunction
    function automatic void qpop(int un);
        if (un == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endfunction
    function automatic void qclear(int un);
        if (un == 0) q0.delete(); else q1.delete();
    endfunction

    function automatic void chk(string name, int un, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s unit%0d @cyc %0d: got %0d expected %0d", name, un, cyc, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // ms: 0 = idle, 1 = scanning since t0, 2 = word waiting for ready
    int         ms[2];
    int         t0[2];
    logic [3:0] wd[2];

    always @(negedge clk) begin
        for (int un = 0; un < 2; un++) begin
            if (rst) begin
                ms[un] = 0;
                t0[un] = 0;
                qclear(un);
            end else begin
                int d;
                int j;
                d = dw(un);
                chk("sel", un, int'(sel_a[un]), (ms[un] == 1) ? (cyc - t0[un]) / d : 0);
                chk("busy", un, int'(busy_a[un]), (ms[un] != 0) ? 1 : 0);
                // decide what the coming rising edge does
                case (ms[un])
                    0: if (start_a[un]) begin
                        ms[un] = 1;
                        t0[un] = cyc + 1;
                    end
                    1: begin
                        j = cyc + 1 - t0[un];
                        if (j % d == 0) begin
                            wd[un][j / d - 1] = in_a[un][j / d - 1];
                            if (j == 4 * d) begin
                                qpush(un, wd[un]);
                                ms[un] = 2;
                            end
                        end
                    end
                    default: if (ready_a[un]) begin
                        if (start_a[un]) begin
                            ms[un] = 1;
                            t0[un] = cyc + 1;
                        end else begin
                            ms[un] = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- output monitor ----------------
    always @(posedge clk) begin
        #2;
        for (int un = 0; un < 2; un++) begin
            if (!rst) begin
                chk("out_valid", un, int'(ov_a[un]), (qsize(un) != 0) ? 1 : 0);
                if (ov_a[un] && qsize(un) != 0) begin
                    chk("out_data", un, int'(od_a[un]), int'(qfront(un)));
                    if (ready_a[un]) qpop(un);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(int un);
        chk("rst_sel", un, int'(sel_a[un]), 0);
        chk("rst_valid", un, int'(ov_a[un]), 0);
        chk("rst_busy", un, int'(busy_a[un]), 0);
        chk("rst_data", un, int'(od_a[un]), 0);
    endtask

    initial begin
        rst     = 1'b0;
        start_a = '0;
        ready_a = '0;
        in_a    = '0;
        #1 rst = 1'b1;
        #2;
        chk_reset(0);
        chk_reset(1);
        step(2);
        rst = 1'b0;
        step(1);

        // basic frame, DWELL = 1
        in_a[0] = 4'b1010; ready_a[0] = 1'b1; start_a[0] = 1'b1;
        step(1);
        start_a[0] = 1'b0;
        step(8);
        chk("held_word_d1", 0, int'(od_a[0]), 'b1010);

        // basic frame, DWELL = 3
        in_a[1] = 4'b0110; ready_a[1] = 1'b1; start_a[1] = 1'b1;
        step(1);
        start_a[1] = 1'b0;
        step(16);
        chk("held_word_d3", 1, int'(od_a[1]), 'b0110);

        // backpressure: word frozen while inputs change and start toggles
        ready_a[0] = 1'b0; in_a[0] = 4'b0101; start_a[0] = 1'b1;
        step(1);
        start_a[0] = 1'b0;
        step(5);
        in_a[0] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            start_a[0] = i[0];
            step(1);
        end
        start_a[0] = 1'b0; ready_a[0] = 1'b1;
        step(3);

        // back-to-back frames
        in_a[0] = 4'b0001; start_a[0] = 1'b1;
        step(5);
        in_a[0] = 4'b1000;
        step(5);
        start_a[0] = 1'b0;
        step(6);

        // start held during the first scan cycles must not restart the frame
        in_a[1] = 4'b1011; start_a[1] = 1'b1;
        step(3);
        start_a[1] = 1'b0;
        step(14);

        // asynchronous reset in the middle of channel 2 (DWELL = 3)
        in_a[1] = 4'b0111; start_a[1] = 1'b1;
        step(1);
        start_a[1] = 1'b0;
        step(7);
        #2 rst = 1'b1;
        #1;
        chk_reset(1);
        step(1);
        rst = 1'b0;
        in_a[1] = 4'b1001; start_a[1] = 1'b1;
        step(1);
        start_a[1] = 1'b0;
        step(16);

        // randomized traffic on both units
        for (int i = 0; i < 400; i++) begin
            for (int un = 0; un < 2; un++) begin
                in_a[un]    = 4'($urandom);
                start_a[un] = ($urandom_range(0, 3) != 0);
                ready_a[un] = ($urandom_range(0, 2) != 0);
            end
            step(1);
        end

        start_a = '0;
        ready_a = '1;
        step(20);
        chk("drained", 0, qsize(0), 0);
        chk("drained", 1, qsize(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_scan_capture.md
# mux_scan_capture

Sequencer that sits directly upstream of the 4:1 decoder/tri-state multiplexer and drives its 2-bit select. It scans select codes 0 to 3 and samples the mux's single-bit output on each. It packs the four samples into a 4-bit word and hands the word downstream over a valid/ready handshake. Together with the mux, it turns four parallel inputs into one time-multiplexed line and back into a registered word.

## Interface
- DWELL, default 1: cycles `sel` is held per channel before sampling; legal range 1..15.
- CNT_W, default 4: dwell counter width; must satisfy 2^CNT_W > DWELL.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one scan frame; a level, sampled only in IDLE or on a DONE-state handshake edge.
- sel  output  2  select code to the mux; registered.
- y_in  input  1  mux output.
- out_data  output  4  captured word; out_data[k] = y_in sampled while sel == k.
- out_valid  output  1  captured word available.
- out_ready  input  1  downstream accepts the word.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: waiting for start.
  - SCAN: channel register ch and dwell counter cnt active.
  - DONE: word presented downstream.
- Reset (asynchronous, any state):
  - state = IDLE
  - sel = 0, ch = 0, cnt = 0
  - out_data = 4'b0000
  - out_valid = 0, busy = 0
- IDLE:
  - start = 1 at an edge: go to SCAN, ch = 0, cnt = 0, sel = 0.
  - Otherwise sel holds 0.
- SCAN:
  - sel = ch at all times.
  - While cnt < DWELL-1: cnt increments each edge.
  - When cnt == DWELL-1: the edge writes y_in into data bit ch.
    - If ch < 3: ch increments, cnt clears to 0, sel follows ch.
    - If ch == 3: go to DONE.
- DONE:
  - out_valid = 1; out_data holds all four bits and stays stable until the transfer.
  - sel returns to 0.
  - Transfer happens at an edge where out_valid and out_ready are both 1.
    - After a transfer with start = 1: go straight to SCAN with ch = 0 (back-to-back frames).
    - After a transfer with start = 0: go to IDLE.
  - Without a transfer: stay in DONE; start is ignored.
- start is ignored throughout SCAN; scans are never restarted or aborted except by rst.
- out_data is updated only by the SCAN sample edges. It keeps its last value after a transfer.
- Data bits for channels not yet sampled in the current frame keep their previous-frame values internally. out_data is only qualified by out_valid.
- y_in is sampled as-is; X/Z on y_in propagates into out_data (bench must drive known inputs).

## Timing
- Let T0 be the edge at which start is accepted.
- Frame timing:
  - sel = 0 during cycles T0..T0+DWELL.
  - The sample for channel k is taken at edge T0 + (k+1)·DWELL.
  - out_valid rises after edge T0 + 4·DWELL.
  - Frame latency, start edge to out_valid: 4·DWELL cycles.
- The mux is combinational, so the y_in path is same-cycle. With DWELL = 1, y_in must settle within one cycle of a sel change.
- Throughput with out_ready held high and start held high:
  - one word per 4·DWELL + 1 cycles;
  - the DONE cycle is mandatory.
- out_valid and out_data are registered; no combinational path from out_ready to any output.
- busy is registered from state: high from T0+1 until the edge after the final transfer returns to IDLE.
- rst during SCAN or DONE:
  - outputs reach reset values immediately, with no clock needed;
  - a pending word is discarded.

## Structure
- A shared package holds:
  - state encoding localparams: IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  - NUM_CH = 4;
  - SEL_W = 2.
- One sub-module is natural: dwell_counter (CNT_W wide, clear/enable inputs, terminal-count output at DWELL-1). It is reused by other sequencers in the codebase.
- The bench instantiates mux_4_1_dec_buf between sel and y_in, with the bench driving the mux's 4-bit in.

## Test plan
- Reset behaviour: assert rst asynchronously mid-cycle during SCAN with ch = 2 -> sel = 0, out_valid = 0, busy = 0, out_data = 0000 immediately; the next start begins again at ch = 0.
- Basic frame, DWELL = 1: mux in = 4'b1010, pulse start at T0 with out_ready = 1 -> sel sequence 0,1,2,3; out_valid high only after edge T0+4; out_data = 1010; transfer on the next edge; return to IDLE.
- DWELL = 3: mux in = 4'b0110 -> each sel held 3 cycles; out_valid rises after T0+12; out_data = 0110.
- Backpressure: out_ready = 0 for 5 cycles in DONE while in changes to 4'b1111 and start pulses -> out_data stays at the old word, state stays DONE; out_ready = 1 -> one transfer, state goes to IDLE.
- Back-to-back frames: start and out_ready held high; in = 4'b0001 then 4'b1000 -> words 0001 and 1000 delivered 5 cycles apart (DWELL = 1); no sample skipped.
- start during SCAN: extra start pulses at T0+1 and T0+2 -> no restart; exactly one word produced.
